// File: rtl/dot_accel_if.sv
// Avalon-MM bus bundle for the dot-product accelerator.
// The slave modport is the accelerator view; master is the system side.
interface dot_accel_if;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;

  modport slave (
    output slave_waitrequest,
    output slave_readdata,
    output master_address,
    output master_read,
    input  slave_address,
    input  slave_read,
    input  slave_write,
    input  slave_writedata,
    input  master_waitrequest,
    input  master_readdata,
    input  master_readdatavalid
  );

  modport master (
    input  slave_waitrequest,
    input  slave_readdata,
    input  master_address,
    input  master_read,
    output slave_address,
    output slave_read,
    output slave_write,
    output slave_writedata,
    output master_waitrequest,
    output master_readdata,
    output master_readdatavalid
  );
endinterface

// File: rtl/dot_accel.sv
// Q16.16 dot-product accelerator: fetches weight/activation pairs
// over an Avalon-MM master and accumulates their products.
module dot_accel (
  input logic clk,
  input logic reset,
  dot_accel_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, RD_W, WT_W, RD_A, WT_A, MAC, DONE
  } state_t;

  state_t      state;
  logic [31:0] w_base;
  logic [31:0] a_base;
  logic [31:0] n_len;
  logic [31:0] w_ptr;
  logic [31:0] a_ptr;
  logic [31:0] n_run;
  logic [31:0] idx;
  logic [31:0] acc;
  logic [31:0] result;
  logic [31:0] w_dat;
  logic [31:0] a_dat;
  logic        start_q;
  logic [63:0] prod;
  logic [31:0] term;
  logic        busy;
  logic        wr0;
  logic        rd0;

  // start_q covers the cycle between the start write and leaving IDLE
  assign busy = (state != IDLE) || start_q;
  assign wr0  = bus.slave_write && (bus.slave_address == 4'd0);
  assign rd0  = bus.slave_read && (bus.slave_address == 4'd0);

  assign prod = 64'($signed(w_dat)) * 64'($signed(a_dat));
  assign term = 32'(prod >> 16);

  assign bus.slave_waitrequest = rd0 && busy;

  always_comb begin
    bus.slave_readdata = '0;
    unique case (1'b1)
      bus.slave_address == 4'd0: bus.slave_readdata = result;
      bus.slave_address == 4'd2: bus.slave_readdata = w_base;
      bus.slave_address == 4'd3: bus.slave_readdata = a_base;
      bus.slave_address == 4'd5: bus.slave_readdata = n_len;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      w_base             <= '0;
      a_base             <= '0;
      n_len              <= '0;
      w_ptr              <= '0;
      a_ptr              <= '0;
      n_run              <= '0;
      idx                <= '0;
      acc                <= '0;
      result             <= '0;
      w_dat              <= '0;
      a_dat              <= '0;
      start_q            <= 1'b0;
      bus.master_read    <= 1'b0;
      bus.master_address <= '0;
    end else begin
      if (bus.slave_write) begin
        unique case (1'b1)
          bus.slave_address == 4'd2: w_base <= bus.slave_writedata;
          bus.slave_address == 4'd3: a_base <= bus.slave_writedata;
          bus.slave_address == 4'd5: n_len  <= bus.slave_writedata;
          default: ;
        endcase
      end

      if (wr0 && !busy) begin
        w_ptr   <= w_base;
        a_ptr   <= a_base;
        n_run   <= n_len;
        idx     <= '0;
        acc     <= '0;
        start_q <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start_q) begin
            start_q <= 1'b0;
            if (n_run == 32'd0) begin
              state <= DONE;
            end else begin
              state              <= RD_W;
              bus.master_read    <= 1'b1;
              bus.master_address <= w_ptr;
            end
          end
        end
        RD_W: begin
          if (!bus.master_waitrequest) begin
            bus.master_read <= 1'b0;
            state           <= WT_W;
          end
        end
        WT_W: begin
          if (bus.master_readdatavalid) begin
            w_dat              <= bus.master_readdata;
            state              <= RD_A;
            bus.master_read    <= 1'b1;
            bus.master_address <= a_ptr;
          end
        end
        RD_A: begin
          if (!bus.master_waitrequest) begin
            bus.master_read <= 1'b0;
            state           <= WT_A;
          end
        end
        WT_A: begin
          if (bus.master_readdatavalid) begin
            a_dat <= bus.master_readdata;
            state <= MAC;
          end
        end
        MAC: begin
          acc   <= acc + term;
          w_ptr <= w_ptr + 32'd4;
          a_ptr <= a_ptr + 32'd4;
          if (idx + 32'd1 < n_run) begin
            idx                <= idx + 32'd1;
            state              <= RD_W;
            bus.master_read    <= 1'b1;
            bus.master_address <= w_ptr + 32'd4;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          result <= acc;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_accel.sv
// Directed self-checking bench for dot_accel with a
// behavioural Avalon-MM memory responder.
module tb_dot_accel;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dot_accel_if bus ();
  dot_accel dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;

  bit [31:0] mem [bit [31:0]];
  int stall_cycles = 0;
  int rdv_delay = 1;
  int stall_bad = 0;
  int stall_cnt = 0;
  int cd = 0;
  int rd_seen = 0;
  logic [31:0] hold_addr = '0;
  logic [31:0] pend_addr = '0;
  logic [31:0] addr_log [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_BEEF;
  endfunction

  // memory side: stalls each read, returns data rdv_delay cycles later
  always @(negedge clk) begin
    bus.master_readdatavalid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata = mem_rd(pend_addr);
      end
    end
    if (bus.master_read === 1'b1) begin
      rd_seen++;
      if (stall_cnt == 0) hold_addr = bus.master_address;
      else if (bus.master_address !== hold_addr) stall_bad++;
      if (stall_cnt < stall_cycles) begin
        bus.master_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        bus.master_waitrequest = 1'b0;
        stall_cnt = 0;
        addr_log.push_back(bus.master_address);
        pend_addr = bus.master_address;
        cd = rdv_delay;
      end
    end else begin
      if (stall_cnt != 0) stall_bad++;
      stall_cnt = 0;
      bus.master_waitrequest = 1'b0;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.slave_address = a;
    bus.slave_writedata = d;
    bus.slave_write = 1'b1;
    @(posedge clk);
    #1;
    bus.slave_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d,
                    output int waits);
    waits = 0;
    @(negedge clk);
    bus.slave_address = a;
    bus.slave_read = 1'b1;
    #1;
    while (bus.slave_waitrequest === 1'b1 && waits < 1000) begin
      @(negedge clk);
      #1;
      waits++;
    end
    d = bus.slave_readdata;
    @(posedge clk);
    #1;
    bus.slave_read = 1'b0;
  endtask

  task automatic load_basic();
    mem[32'h1000] = 32'h0001_0000;
    mem[32'h1004] = 32'h0002_0000;
    mem[32'h1008] = 32'hFFFF_8000;
    mem[32'h2000] = 32'h0002_0000;
    mem[32'h2004] = 32'h0000_8000;
    mem[32'h2008] = 32'h0004_0000;
    wr(4'd2, 32'h1000);
    wr(4'd3, 32'h2000);
    wr(4'd5, 32'd3);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int w;
    wr(4'd2, 32'h55);
    wr(4'd3, 32'h66);
    wr(4'd5, 32'h77);
    @(negedge clk);
    reset = 1'b1;
    bus.slave_address = 4'd2;
    bus.slave_writedata = 32'hABCD;
    bus.slave_write = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.slave_write = 1'b0;
    n_checks++;
    if (bus.master_read !== 1'b0 || bus.master_address !== 32'h0)
      $display("FAIL reset_master got rd=%b addr=%h exp 0/0",
               bus.master_read, bus.master_address);
    else n_pass++;
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0 || w !== 0)
      $display("FAIL reset_result got %h waits %0d exp 0 waits 0", d, w);
    else n_pass++;
    rd(4'd2, d, w);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_w_prio got %h exp 0", d);
    else n_pass++;
    rd(4'd3, d, w);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_a got %h exp 0", d);
    else n_pass++;
    rd(4'd5, d, w);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_n got %h exp 0", d);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [31:0] e;
    int w;
    load_basic();
    rd(4'd3, d, w);
    n_checks++;
    if (d !== 32'h2000 || w !== 0)
      $display("FAIL cfg_read got %h waits %0d exp 00002000 waits 0", d, w);
    else n_pass++;
    rd(4'd7, d, w);
    n_checks++;
    if (d !== 32'h0) $display("FAIL unmapped_read got %h exp 0", d);
    else n_pass++;
    addr_log.delete();
    wr(4'd0, 32'h0);
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0001_0000)
      $display("FAIL basic_result got %h exp 00010000", d);
    else n_pass++;
    n_checks++;
    if (w !== 17) $display("FAIL basic_latency got %0d exp 17", w);
    else n_pass++;
    n_checks++;
    if (addr_log.size() !== 6)
      $display("FAIL basic_nreads got %0d exp 6", addr_log.size());
    else n_pass++;
    for (int i = 0; i < addr_log.size() && i < 6; i++) begin
      e = ((i % 2) == 0 ? 32'h1000 : 32'h2000) + 32'(4 * (i / 2));
      n_checks++;
      if (addr_log[i] !== e)
        $display("FAIL basic_addr%0d got %h exp %h", i, addr_log[i], e);
      else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] d;
    int w;
    wr(4'd5, 32'd0);
    rd_seen = 0;
    wr(4'd0, 32'h0);
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0 || w > 3)
      $display("FAIL zero_result got %h waits %0d exp 0 waits<=3", d, w);
    else n_pass++;
    n_checks++;
    if (rd_seen !== 0) $display("FAIL zero_noread got %0d exp 0", rd_seen);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic [31:0] e;
    int w;
    wr(4'd5, 32'd3);
    stall_cycles = 3;
    rdv_delay = 4;
    stall_bad = 0;
    addr_log.delete();
    wr(4'd0, 32'h0);
    rd(4'd0, d, w);
    stall_cycles = 0;
    rdv_delay = 1;
    n_checks++;
    if (d !== 32'h0001_0000)
      $display("FAIL stall_result got %h exp 00010000", d);
    else n_pass++;
    n_checks++;
    if (w !== 53) $display("FAIL stall_latency got %0d exp 53", w);
    else n_pass++;
    n_checks++;
    if (stall_bad !== 0)
      $display("FAIL stall_stable got %0d glitches exp 0", stall_bad);
    else n_pass++;
    n_checks++;
    if (addr_log.size() !== 6)
      $display("FAIL stall_nreads got %0d exp 6", addr_log.size());
    else n_pass++;
    for (int i = 0; i < addr_log.size() && i < 6; i++) begin
      e = ((i % 2) == 0 ? 32'h1000 : 32'h2000) + 32'(4 * (i / 2));
      n_checks++;
      if (addr_log[i] !== e)
        $display("FAIL stall_addr%0d got %h exp %h", i, addr_log[i], e);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int w;
    mem[32'h3000] = 32'h7FFF_0000;
    mem[32'h3004] = 32'h7FFF_0000;
    mem[32'h4000] = 32'h0001_0000;
    mem[32'h4004] = 32'h0001_0000;
    wr(4'd2, 32'h3000);
    wr(4'd3, 32'h4000);
    wr(4'd5, 32'd2);
    wr(4'd0, 32'h0);
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'hFFFE_0000)
      $display("FAIL overflow_result got %h exp fffe0000", d);
    else n_pass++;
    n_checks++;
    if (w !== 12) $display("FAIL overflow_latency got %0d exp 12", w);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int w;
    int t;
    load_basic();
    rdv_delay = 4;
    addr_log.delete();
    wr(4'd0, 32'h0);
    t = 0;
    while (addr_log.size() < 4 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_checks++;
    if (t >= 200) $display("FAIL rmid_reach got timeout exp 4 reads");
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_seen = 0;
    n_checks++;
    if (bus.master_read !== 1'b0)
      $display("FAIL rmid_mread got %b exp 0", bus.master_read);
    else n_pass++;
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0 || w !== 0)
      $display("FAIL rmid_idle got %h waits %0d exp 0 waits 0", d, w);
    else n_pass++;
    repeat (6) @(negedge clk);
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0 || w !== 0 || rd_seen !== 0)
      $display("FAIL rmid_stray got %h waits %0d reads %0d exp 0/0/0",
               d, w, rd_seen);
    else n_pass++;
    rdv_delay = 1;
    load_basic();
    wr(4'd0, 32'h0);
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0001_0000)
      $display("FAIL rmid_restart got %h exp 00010000", d);
    else n_pass++;
  endtask

  task automatic test_busy();
    logic [31:0] d;
    int w;
    wr(4'd5, 32'd3);
    addr_log.delete();
    wr(4'd0, 32'h0);
    wr(4'd0, 32'h0);
    wr(4'd5, 32'd1);
    wr(4'd0, 32'h0);
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0001_0000 || addr_log.size() !== 6)
      $display("FAIL busy_result got %h reads %0d exp 00010000 reads 6",
               d, addr_log.size());
    else n_pass++;
    rd(4'd5, d, w);
    n_checks++;
    if (d !== 32'd1) $display("FAIL busy_nlen got %h exp 1", d);
    else n_pass++;
    addr_log.delete();
    wr(4'd0, 32'h0);
    rd(4'd0, d, w);
    n_checks++;
    if (d !== 32'h0002_0000 || addr_log.size() !== 2)
      $display("FAIL busy_next got %h reads %0d exp 00020000 reads 2",
               d, addr_log.size());
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.slave_address = '0;
    bus.slave_read = 1'b0;
    bus.slave_write = 1'b0;
    bus.slave_writedata = '0;
    bus.master_waitrequest = 1'b0;
    bus.master_readdata = '0;
    bus.master_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dot_accel.md
DOT_ACCEL -- requirements
Module: dot_accel

Interface
REQ-001 SHALL have no parameters; data format is fixed at signed Q16.16, 32-bit.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 slave_waitrequest  out  1  Avalon-MM slave stall.
REQ-005 slave_address  in  4  word offset into the register map.
REQ-006 slave_read / slave_write  in  1 each  slave read and write strobes.
REQ-007 slave_writedata  in  32; slave_readdata  out  32.
REQ-008 master_waitrequest  in  1  SDRAM-side stall.
REQ-009 master_address  out  32  byte address.
REQ-010 master_read  out  1  read strobe.
REQ-011 master_readdata  in  32; master_readdatavalid  in  1.

Function
REQ-012 Register map (word offsets):
- 0: write = start, read = result.
- 2: weight base byte address (W).
- 3: activation base byte address (A).
- 5: vector length N, 32-bit unsigned.
- Other offsets read 0; writes to them are ignored.
REQ-013 Start operation:
- A write to offset 0 in IDLE latches W, A and N into working copies.
- It clears the accumulator and leaves IDLE on the next edge.
- A write to offset 0 while busy is ignored.
REQ-014 Config writes (offsets 2, 3, 5) are accepted in any state; they affect only the next start.
REQ-015 Slave reads of offsets 2, 3, 5: slave_waitrequest low, slave_readdata combinational from the register, zero-wait.
REQ-016 Slave read of offset 0:
- While busy: slave_waitrequest high.
- In IDLE: slave_waitrequest low and slave_readdata equals the last result.
- Result is 0 after reset.
REQ-017 slave_waitrequest is low in all other cases, including writes.
REQ-018 FSM states and transitions:
- IDLE -> RD_W on start with N != 0.
- RD_W -> WT_W when master_waitrequest = 0.
- WT_W -> RD_A on master_readdatavalid.
- RD_A -> WT_A when master_waitrequest = 0.
- WT_A -> MAC on master_readdatavalid.
- MAC -> RD_W if index + 1 < N, else DONE.
- DONE -> IDLE.
REQ-019 Start with N = 0 goes to DONE directly; the result becomes 0.
REQ-020 In RD_W/RD_A, master_read = 1 and master_address is held stable until master_waitrequest = 0; master_read = 0 in all other states.
REQ-021 Master addresses:
- Weight address = W + 4*i; activation address = A + 4*i, modulo 2^32.
- i runs 0..N-1.
- At most one read is outstanding.
REQ-022 Weight data is captured on master_readdatavalid in WT_W; activation data is captured on master_readdatavalid in WT_A. master_readdatavalid in any other state is ignored.
REQ-023 MAC arithmetic:
- Product = signed 32x32 -> 64-bit.
- Term = product[47:16], truncated (no rounding).
- acc <= acc + term, 32-bit two's-complement wrap, no saturation.
REQ-024 DONE copies acc to the result register; an offset-0 read stalled in WT/RD states completes in IDLE on the following cycle.
REQ-025 Latency with zero-wait master and single-cycle readdatavalid: 5N + 2 cycles from the start-write edge to IDLE.

Reset
REQ-026 When reset = 1 at a clock edge, the block SHALL:
- enter IDLE;
- clear W, A, N, working copies, index, accumulator and result to 0;
- drive master_read = 0, master_address = 0 and slave_waitrequest = 0.
REQ-027 Reset mid-operation abandons any outstanding read; master_readdatavalid arriving after reset is ignored.
REQ-028 Reset has priority over any simultaneous slave write.

Verification
REQ-029 Basic dot product:
- W = 0x1000: [0x00010000, 0x00020000, 0xFFFF8000].
- A = 0x2000: [0x00020000, 0x00008000, 0x00040000].
- N = 3, start.
- Offset-0 read returns 0x00010000 (1.0).
- Master addresses in order: 0x1000, 0x2000, 0x1004, 0x2004, 0x1008, 0x2008.
REQ-030 N = 0, start -> no master_read ever asserted; offset-0 read returns 0x00000000 within 3 cycles of start.
REQ-031 Master stall:
- Same vectors as REQ-029.
- master_waitrequest held high 3 cycles per read, readdatavalid delayed 4 cycles.
- Required: identical result 0x00010000; master_address/master_read stable throughout each stall.
REQ-032 Overflow:
- N = 2, weights [0x7FFF0000, 0x7FFF0000], activations [0x00010000, 0x00010000].
- Required: result 0xFFFE0000 (wrapped).
REQ-033 Reset mid-operation:
- Assert reset in WT_A of element 1.
- Required: next cycle IDLE, master_read = 0, result reads 0.
- A stray readdatavalid is ignored.
- A new start then produces the correct result.
REQ-034 Busy behaviour:
- A write to offset 0 while busy does not restart: the result matches the uninterrupted run.
- A write to offset 5 while busy does not change the current run's length.
